div_ctrl: RTL
=============

// Module: div_ctrl
// PURPOSE
//  Multi-cycle divider sequencer for DIV/DIVU: radix-2 restoring division, one quotient bit per clock.
//  The EX stage starts it, holds start_i high while stalling, and takes the result when ready_o is high.
//  result_o = {remainder, quotient} is written to {HI,LO} through the existing hi_o/lo_o/whilo_o path.
//  Sits beside EX; owns no HI/LO state itself.
// PARAMETERS
//  DATA_W   32   operand width; result_o is 2*DATA_W; iteration counter is $clog2(DATA_W)+1 bits
// PORTS
//  clk           in   1         clock
//  rst           in   1         synchronous, active-high reset (single clock domain)
//  signed_div_i  in   1         1 = DIV (two's complement), 0 = DIVU
//  opdata1_i     in   DATA_W    dividend; sampled only on the accepting edge
//  opdata2_i     in   DATA_W    divisor; sampled only on the accepting edge
//  start_i       in   1         request; must stay high until ready_o is seen
//  annul_i       in   1         abort in-flight divide (branch flush / exception)
//  result_o      out  2*DATA_W  {remainder, quotient}; registered
//  ready_o       out  1         result_o valid; registered
// BEHAVIOUR
//  Reset (edge with rst=1): state=FREE, cnt=0, result_o=0, ready_o=0. Overrides all other inputs, mid-operation included.
//  States:
//  - FREE: start_i=1 & annul_i=0 -> accept (edge E0). Divisor==0 -> BYZERO, else -> ON.
//    On accept: latch magnitudes (negate negative operands when signed_div_i=1), latch both sign bits, cnt=0.
//  - BYZERO: next edge -> END; stored quotient=0, remainder=0.
//  - ON: each edge shifts {rem,dvd} left 1; trial = rem - divisor.
//    If trial >= 0: rem=trial, quotient bit=1; else quotient bit=0. cnt++.
//    Edges E1..E_DATA_W do the iterations; on the last one (cnt==DATA_W-1) -> END.
//    Signed fixup applied on entry to END:
//      quotient negated iff dividend sign != divisor sign;
//      remainder takes the dividend's sign.
//  - END: first edge in END registers result_o and sets ready_o=1.
//    Stays in END with outputs held while start_i=1.
//    start_i=0 -> FREE; ready_o=0 and result_o=0 on that edge.
//  Latency: ready_o high after edge E(DATA_W+1), i.e. 33 edges for DATA_W=32. Divide-by-zero: after edge E2.
//  Abort: annul_i=1, or start_i=0, in BYZERO or ON -> FREE on that edge; ready_o=0, result_o=0, no result is produced.
//    annul_i=1 in END -> FREE and outputs cleared.
//    annul_i has priority over start_i in every state.
//  Back-to-back: a new request is accepted only from FREE, so a minimum of 1 idle cycle separates divides.
//  Overflow: signed -2^(DATA_W-1) / -1 wraps; quotient=0x80000000, remainder=0. No flag.
//  ready_o never asserts in the same cycle an abort is sampled.
// CONFIGURATION
//  DIV_EARLY_EXIT_EN defined:
//    In FREE, divisor!=0 and |dividend| < |divisor| (unsigned magnitude compare) -> straight to END.
//    Quotient=0, remainder=original dividend (sign preserved); ready_o after edge E1.
//    |dividend|==|divisor| still takes the full iterative path.
//  DIV_EARLY_EXIT_EN undefined: every nonzero-divisor request takes the full DATA_W-iteration path.
//  Results are identical either way; only latency differs.
// TESTING
//  1. DIVU 100/7, start_i held -> ready_o after edge E33; result_o={32'd2,32'd14}; held until start_i=0, then ready_o=0.
//  2. DIV -7/2 (0xFFFFFFF9/0x2) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
//     DIV 7/-2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
//  3. DIVU 5/0 -> ready_o after edge E2, result_o=64'h0.
//  4. annul_i pulsed at iteration 10 -> FREE next edge, ready_o stays 0.
//     A new DIVU 9/3 one cycle later -> {0, 3} after E33.
//  5. DIV 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0.
//     rst asserted at iteration 20 -> next cycle FREE, outputs 0.
//  6. DIVU 3/10 with DIV_EARLY_EXIT_EN -> {3, 0} after E1; without it -> same result after E33.

Source files
------------

// File: rtl/div_ctrl.sv
// ============================================================================
// div_ctrl : radix-2 restoring DIV/DIVU sequencer, one quotient bit per clock.
// Optional early exit for |dividend| < |divisor| under DIV_EARLY_EXIT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module div_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_FREE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]   dvd_q, dvd_d;
  logic [DATA_W-1:0]   dsr_q, dsr_d;
  logic                sign_n_q, sign_n_d;
  logic                sign_d_q, sign_d_d;
  logic [2*DATA_W-1:0] result_q, result_d;
  logic                ready_q, ready_d;

  logic [DATA_W-1:0]   mag1, mag2;
  logic [DATA_W:0]     trial;
  logic [DATA_W-1:0]   q_step, r_step;

  assign mag1 = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
  assign mag2 = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

  // dvd_q shifts its MSB into the remainder and fills with quotient bits
  assign trial  = {rem_q, dvd_q[DATA_W-1]} - {1'b0, dsr_q};
  assign q_step = {dvd_q[DATA_W-2:0], ~trial[DATA_W]};
  assign r_step = trial[DATA_W] ? {rem_q[DATA_W-2:0], dvd_q[DATA_W-1]}
                                : trial[DATA_W-1:0];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    dsr_d    = dsr_q;
    sign_n_d = sign_n_q;
    sign_d_d = sign_d_q;
    result_d = result_q;
    ready_d  = ready_q;

    unique case (state_q)
      S_FREE: begin
        if (start_i && !annul_i) begin
          sign_n_d = signed_div_i & opdata1_i[DATA_W-1];
          sign_d_d = signed_div_i & opdata2_i[DATA_W-1];
          cnt_d    = '0;
          rem_d    = '0;
          dvd_d    = mag1;
          dsr_d    = mag2;
          if (opdata2_i == '0) begin
            state_d = S_BYZERO;
`ifdef DIV_EARLY_EXIT_EN
          end else if (mag1 < mag2) begin
            // Quotient is zero; remainder is the dividend exactly as given
            state_d = S_END;
            rem_d   = opdata1_i;
            dvd_d   = '0;
`endif
          end else begin
            state_d = S_ON;
          end
        end
      end

      S_BYZERO: begin
        if (annul_i || !start_i) begin
          state_d  = S_FREE;
          ready_d  = 1'b0;
          result_d = '0;
        end else begin
          state_d = S_END;
          rem_d   = '0;
          dvd_d   = '0;
        end
      end

      S_ON: begin
        if (annul_i || !start_i) begin
          state_d  = S_FREE;
          ready_d  = 1'b0;
          result_d = '0;
        end else begin
          cnt_d = cnt_q + C_CNT_ONE;
          if (cnt_q == C_CNT_LAST) begin
            state_d = S_END;
            dvd_d   = (sign_n_q ^ sign_d_q) ? -q_step : q_step;
            rem_d   = sign_n_q ? -r_step : r_step;
          end else begin
            dvd_d = q_step;
            rem_d = r_step;
          end
        end
      end

      S_END: begin
        if (annul_i || !start_i) begin
          state_d  = S_FREE;
          ready_d  = 1'b0;
          result_d = '0;
        end else begin
          ready_d  = 1'b1;
          result_d = {rem_q, dvd_q};
        end
      end

      default: begin
        state_d  = S_FREE;
        ready_d  = 1'b0;
        result_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FREE;
      cnt_q    <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dsr_q    <= '0;
      sign_n_q <= 1'b0;
      sign_d_q <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      dsr_q    <= dsr_d;
      sign_n_q <= sign_n_d;
      sign_d_q <= sign_d_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

`default_nettype wire
